alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential front-end that drives the 64-bit datapath ALU from the execute stage. It accepts an operation request over a valid/ready handshake and decodes the 2-bit ALUOp plus 6-bit funct field into the ALU's 4-bit opcode. It then presents registered operands to the ALU, captures result and zero flag, and returns them over a second valid/ready handshake. It is the initiator of the ALU opcode/operand interface; the ALU itself stays purely combinational.

## Interface
- WIDTH, 64, operand/result width; must match the ALU.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_aluop  in  2  00 = add (load/store), 01 = sub (branch), 10 = R-type (use funct), 11 = illegal.
- req_funct  in  6  funct field, used only when req_aluop = 10.
- req_a, req_b  in  WIDTH  operands.
- alu_opcode  out  4  opcode to ALU: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- alu_a, alu_b  out  WIDTH  registered operands to ALU.
- alu_result  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  request was illegal; rsp_data/rsp_zero are 0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: req_ready = 1. On req_valid:
  - Latch req_a/req_b into alu_a/alu_b.
  - Latch the decoded opcode into alu_opcode.
  - Legal requests go to EXEC. Illegal requests go to RESP with rsp_err = 1, rsp_data = 0, rsp_zero = 0; alu_* registers are left unchanged.
- EXEC: alu_* stable for one full cycle. At the next edge, rsp_data <= alu_result, rsp_zero <= alu_zero, rsp_err <= 0, then go to RESP.
- RESP: rsp_valid = 1. rsp_* hold until rsp_valid && rsp_ready at an edge, then go to IDLE.
- Decode:
  - aluop 00 → 0010.
  - aluop 01 → 0110.
  - aluop 10 with funct 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001.
  - Any other funct with aluop 10, and aluop 11, → illegal.
- Arithmetic is done by the ALU, WIDTH bits, wrap-around, no carry/overflow output. This block never alters alu_result.
- alu_opcode is never driven to an unsupported value, because the ALU output is undefined (high-Z) for those codes. rsp_data is captured only in EXEC.
- No pipelining: one outstanding request. req_ready = 0 in EXEC and RESP.

## Timing
- Reset values (asynchronous, immediate):
  - State: IDLE.
  - req_ready 1, rsp_valid 0, rsp_data 0, rsp_zero 0, rsp_err 0.
  - alu_opcode 0000, alu_a 0, alu_b 0.
- Legal op: accepted at edge E0. ALU inputs valid after E0. Captured and rsp_valid = 1 after E1. Earliest next accept is at the edge after the response handshake. Minimum 3 cycles per op with rsp_ready held high.
- Illegal op: rsp_valid = 1 after E0 (1-cycle latency).
- Simultaneous req_valid during RESP is ignored; req_ready is low.
- Response handshake and new request in the same cycle: the request is not accepted in that cycle. It is accepted in the following IDLE cycle.
- rsp_ready low: response held indefinitely, values stable.
- rst mid-EXEC or mid-RESP: transaction dropped, all outputs to reset values, no response emitted.

## Test plan
- Reset then R-type ADD: a = 5, b = 7, aluop 10, funct 100000 → alu_opcode 0010; rsp_data 12, rsp_zero 0, rsp_err 0, rsp_valid two edges after accept.
- Branch SUB equal and wrap: a = b = 0x1234 with aluop 01 → rsp_data 0, rsp_zero 1. Then a = 0, b = 1 → rsp_data 0xFFFF_FFFF_FFFF_FFFF, rsp_zero 0.
- AND/OR: a = 0xF0F0, b = 0x0FF0. funct 100100 → 0x00F0. funct 100101 → 0xFFF0.
- Illegal: aluop 10 with funct 101010, and aluop 11 → rsp_err 1, rsp_data 0, rsp_valid one edge after accept, alu_opcode unchanged.
- Backpressure: rsp_ready low 5 cycles → rsp_valid and rsp_data stable, req_ready 0, a second req_valid not accepted until after the handshake.
- Reset mid-op: assert rst while in EXEC → all outputs immediately at reset values, no rsp_valid pulse. A following ADD of 1 + 1 → 2.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - execute-stage issue controller driving the combinational ALU
// Decodes ALUOp/funct, presents registered operands, captures the result and returns it over a handshake.
module alu_issue_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_err_q, rsp_err_d;
    logic [3:0]         alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;

    logic               dec_legal;
    logic [3:0]         dec_opcode;

    // Only the four supported codes can ever reach alu_opcode; everything else is flagged illegal.
    always_comb begin
        dec_legal  = 1'b0;
        dec_opcode = OP_ADD;
        case (req_aluop)
            2'b00: begin
                dec_legal  = 1'b1;
                dec_opcode = OP_ADD;
            end
            2'b01: begin
                dec_legal  = 1'b1;
                dec_opcode = OP_SUB;
            end
            2'b10: begin
                case (req_funct)
                    6'b100000: begin
                        dec_legal  = 1'b1;
                        dec_opcode = OP_ADD;
                    end
                    6'b100010: begin
                        dec_legal  = 1'b1;
                        dec_opcode = OP_SUB;
                    end
                    6'b100100: begin
                        dec_legal  = 1'b1;
                        dec_opcode = OP_AND;
                    end
                    6'b100101: begin
                        dec_legal  = 1'b1;
                        dec_opcode = OP_OR;
                    end
                    default: begin
                        dec_legal  = 1'b0;
                        dec_opcode = OP_ADD;
                    end
                endcase
            end
            default: begin
                dec_legal  = 1'b0;
                dec_opcode = OP_ADD;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    if (dec_legal) begin
                        alu_opcode_d = dec_opcode;
                        alu_a_d      = req_a;
                        alu_b_d      = req_b;
                        state_d      = EXEC;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_zero_d  = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = alu_result;
                rsp_zero_d  = alu_zero;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                // A request arriving alongside the handshake waits for the next IDLE cycle.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            alu_opcode_q <= OP_AND;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_aluop;
    logic [5:0]       req_funct;
    logic [WIDTH-1:0] req_a, req_b;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_aluop  (req_aluop),
        .req_funct  (req_funct),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    // Scoreboard: a response is popped on the cycle its handshake completes.
    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got data=%h err=%b, expected no response", rsp_data, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_data !== e.data || rsp_zero !== e.zero || rsp_err !== e.err) begin
                    bad++;
                    $display("FAIL sb_rsp: got data=%h zero=%b err=%b, expected data=%h zero=%b err=%b",
                             rsp_data, rsp_zero, rsp_err, e.data, e.zero, e.err);
                end
            end
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic z, input logic e);
        exp_t x;
        x.data = d;
        x.zero = z;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic start_req(input logic [1:0] op, input logic [5:0] fn,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(posedge clk);
        #2;
        req_aluop = op;
        req_funct = fn;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [3:0] op_first);
        lat = 1;
        @(negedge clk);
        op_first = alu_opcode;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] ed, input logic ez, input logic ee,
                          output int lat, output logic [3:0] op_first);
        push_exp(ed, ez, ee);
        start_req(op, fn, a, b);
        wait_rsp(lat, op_first);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0;
        req_aluop = 2'b00;
        req_funct = 6'b0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_zero, rsp_err} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags: got rdy/vld/zero/err=%b, expected 1000",
                     {req_ready, rsp_valid, rsp_zero, rsp_err});
        end
        total++;
        if (rsp_data !== '0 || alu_a !== '0 || alu_b !== '0) begin
            bad++;
            $display("FAIL reset_data: got rsp_data=%h alu_a=%h alu_b=%h, expected 0", rsp_data, alu_a, alu_b);
        end
        total++;
        if (alu_opcode !== 4'b0000) begin
            bad++;
            $display("FAIL reset_opcode: got %b, expected 0000", alu_opcode);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_add;
        int lat;
        logic [3:0] opf;
        run_op(2'b10, 6'b100000, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, lat, opf);
        total++;
        if (opf !== 4'b0010) begin
            bad++;
            $display("FAIL add_opcode: got %b, expected 0010", opf);
        end
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL add_latency: got %0d, expected 2", lat);
        end
    endtask

    task automatic test_sub;
        int lat;
        logic [3:0] opf;
        run_op(2'b01, 6'b000000, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0, lat, opf);
        total++;
        if (opf !== 4'b0110 || lat !== 2) begin
            bad++;
            $display("FAIL sub_eq: got opcode=%b lat=%0d, expected 0110 and 2", opf, lat);
        end
        run_op(2'b01, 6'b111111, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, lat, opf);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL sub_wrap_latency: got %0d, expected 2", lat);
        end
    endtask

    task automatic test_logic;
        int lat;
        logic [3:0] opf;
        run_op(2'b10, 6'b100100, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0, lat, opf);
        total++;
        if (opf !== 4'b0000) begin
            bad++;
            $display("FAIL and_opcode: got %b, expected 0000", opf);
        end
        run_op(2'b10, 6'b100101, 64'hF0F0, 64'h0FF0, 64'hFFF0, 1'b0, 1'b0, lat, opf);
        total++;
        if (opf !== 4'b0001) begin
            bad++;
            $display("FAIL or_opcode: got %b, expected 0001", opf);
        end
        run_op(2'b10, 6'b100010, 64'd9, 64'd4, 64'd5, 1'b0, 1'b0, lat, opf);
        total++;
        if (opf !== 4'b0110) begin
            bad++;
            $display("FAIL rsub_opcode: got %b, expected 0110", opf);
        end
    endtask

    task automatic test_illegal;
        int lat;
        logic [3:0] opf;
        run_op(2'b10, 6'b101010, 64'h55, 64'h66, 64'd0, 1'b0, 1'b1, lat, opf);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL illegal_funct_latency: got %0d, expected 1", lat);
        end
        total++;
        if (alu_opcode !== 4'b0110 || alu_a !== 64'd9 || alu_b !== 64'd4) begin
            bad++;
            $display("FAIL illegal_funct_hold: got opcode=%b a=%h b=%h, expected 0110 9 4",
                     alu_opcode, alu_a, alu_b);
        end
        run_op(2'b11, 6'b100000, 64'h77, 64'h88, 64'd0, 1'b0, 1'b1, lat, opf);
        total++;
        if (lat !== 1 || alu_opcode !== 4'b0110) begin
            bad++;
            $display("FAIL illegal_aluop: got lat=%0d opcode=%b, expected 1 and 0110", lat, alu_opcode);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [3:0] opf;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        run_op(2'b00, 6'b000000, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0, lat, opf);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL bp_latency: got %0d, expected 2", lat);
        end
        push_exp(64'd30, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        req_aluop = 2'b00;
        req_a     = 64'd10;
        req_b     = 64'd20;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 64'd7 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got vld=%b data=%h rdy=%b, expected 1 7 0",
                         i, rsp_valid, rsp_data, req_ready);
            end
        end
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_after_hs: got rdy=%b vld=%b, expected 1 0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0 || alu_a !== 64'd10 || alu_b !== 64'd20) begin
            bad++;
            $display("FAIL bp_second_accept: got rdy=%b a=%h b=%h, expected 0 10 20", req_ready, alu_a, alu_b);
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL bp_second_latency: got %0d extra cycles, expected 1", lat);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [3:0] opf;
        int seen;
        start_req(2'b00, 6'b000000, 64'h40, 64'h2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_zero, rsp_err} !== 4'b1000 || alu_opcode !== 4'b0000
            || alu_a !== '0 || alu_b !== '0 || rsp_data !== '0) begin
            bad++;
            $display("FAIL mid_reset_values: got rdy/vld/zero/err=%b opcode=%b a=%h b=%h data=%h, expected 1000 0000 0 0 0",
                     {req_ready, rsp_valid, rsp_zero, rsp_err}, alu_opcode, alu_a, alu_b, rsp_data);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_reset_no_rsp: got %0d cycles with rsp_valid, expected 0", seen);
        end
        run_op(2'b00, 6'b000000, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, lat, opf);
        total++;
        if (lat !== 2 || opf !== 4'b0010) begin
            bad++;
            $display("FAIL post_reset_add: got lat=%0d opcode=%b, expected 2 0010", lat, opf);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending responses, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
